// File: rtl/fp_pkg.sv
// Shared constants and state type for the FP divider result packer.
package fp_pkg;

    localparam int unsigned SP_BIAS = 127;
    localparam int unsigned HP_BIAS = 15;

    localparam logic [7:0]  SP_EXP_MAX = 8'hFF;
    localparam logic [4:0]  HP_EXP_MAX = 5'd31;

    localparam logic [15:0] HP_QNAN = 16'h7E00;
    localparam logic [15:0] HP_INF  = 16'h7C00;
    localparam logic [15:0] HP_MAX  = 16'h7BFF;
    localparam logic [31:0] SP_QNAN = 32'h7FC00000;
    localparam logic [31:0] SP_INF  = 32'h7F800000;
    localparam logic [31:0] SP_MAX  = 32'h7F7FFFFF;

    localparam logic RM_RNE = 1'b0;
    localparam logic RM_RTZ = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUND = 2'd1,
        ST_PACK  = 2'd2,
        ST_OUT   = 2'd3
    } state_t;

endpackage

// File: rtl/fp_half_rounder.sv
// Combinational 23->10 bit fraction rounder (RNE / RTZ) for half-precision results.
module fp_half_rounder
    import fp_pkg::*;
(
    input  logic [22:0] mant23,
    input  logic        inx_in,
    input  logic        round_mode,
    output logic [9:0]  frac10,
    output logic        carry,
    output logic        inexact
);

    logic [9:0]  keep;
    logic        guard;
    logic        sticky;
    logic        inc;
    logic [10:0] sum;

    assign keep    = mant23[22:13];
    assign guard   = mant23[12];
    assign sticky  = (|mant23[11:0]) | inx_in;
    assign inc     = (round_mode == RM_RNE) & guard & (sticky | keep[0]);
    assign sum     = {1'b0, keep} + {10'd0, inc};
    assign frac10  = sum[9:0];
    assign carry   = sum[10];
    assign inexact = guard | sticky;

endmodule

// File: rtl/fp_result_packer.sv
// Packs the divider's unpacked result into an IEEE-754 half/single word with flags.
// Optional FP_STICKY_FLAGS_EN adds flag_clr / sticky_flags accumulation.
module fp_result_packer
    import fp_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        mode_fp,
    input  logic        round_mode,
    input  logic        res_sign,
    input  logic [7:0]  res_exp,
    input  logic [22:0] res_mant,
    input  logic        ovf_in,
    input  logic        unf_in,
    input  logic        inx_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_word,
    output logic [2:0]  out_flags
`ifdef FP_STICKY_FLAGS_EN
    ,
    input  logic        flag_clr,
    output logic [2:0]  sticky_flags
`endif
);

    state_t      state, state_nxt;

    logic        c_mode, c_rm, c_sign, c_ovf, c_unf, c_inx;
    logic [7:0]  c_exp;
    logic [22:0] c_mant;

    logic [9:0]  rnd_frac, r_frac;
    logic        rnd_carry, r_carry;
    logic        rnd_inx, r_hinx;

    logic [9:0]  h_adj;
    logic        is_nan, is_inf;
    logic [31:0] pk_word;
    logic [2:0]  pk_flags;

    fp_half_rounder u_rounder (
        .mant23     (c_mant),
        .inx_in     (c_inx),
        .round_mode (c_rm),
        .frac10     (rnd_frac),
        .carry      (rnd_carry),
        .inexact    (rnd_inx)
    );

    assign in_ready = (state == ST_IDLE);

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (in_valid) state_nxt = ST_ROUND;
            ST_ROUND: state_nxt = ST_PACK;
            ST_PACK:  state_nxt = ST_OUT;
            ST_OUT:   if (out_valid && out_ready) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Half exponent rebiased from SP, including any rounding carry; signed 10-bit.
    assign h_adj  = {2'b00, c_exp} - 10'(SP_BIAS - HP_BIAS) + {9'd0, r_carry};
    assign is_nan = (c_exp == SP_EXP_MAX) && (c_mant != '0);
    assign is_inf = (c_exp == SP_EXP_MAX) && (c_mant == '0);

    always_comb begin
        pk_word  = '0;
        pk_flags = '0;
        if (is_nan) begin
            pk_word = c_mode ? SP_QNAN : {16'h0000, HP_QNAN};
        end else if (is_inf || c_ovf) begin
            pk_flags = 3'b101;
            pk_word  = c_mode ? {c_sign, (c_rm == RM_RTZ) ? SP_MAX[30:0] : SP_INF[30:0]}
                              : {16'h0000, c_sign, (c_rm == RM_RTZ) ? HP_MAX[14:0] : HP_INF[14:0]};
        end else if ((c_exp == '0) || c_unf) begin
            pk_flags = {1'b0, c_inx | c_unf, c_inx};
            pk_word  = c_mode ? {c_sign, 31'd0} : {16'h0000, c_sign, 15'd0};
        end else if (c_mode) begin
            pk_flags = {2'b00, c_inx};
            pk_word  = {c_sign, c_exp, c_mant};
        end else if ($signed(h_adj) >= $signed({5'd0, HP_EXP_MAX})) begin
            pk_flags = 3'b101;
            pk_word  = {16'h0000, c_sign, (c_rm == RM_RTZ) ? HP_MAX[14:0] : HP_INF[14:0]};
        end else if ($signed(h_adj) <= 0) begin
            pk_flags = 3'b011;
            pk_word  = {16'h0000, c_sign, 15'd0};
        end else begin
            pk_flags = {2'b00, r_hinx};
            pk_word  = {16'h0000, c_sign, h_adj[4:0], r_frac};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            c_mode    <= 1'b0;
            c_rm      <= 1'b0;
            c_sign    <= 1'b0;
            c_exp     <= '0;
            c_mant    <= '0;
            c_ovf     <= 1'b0;
            c_unf     <= 1'b0;
            c_inx     <= 1'b0;
            r_frac    <= '0;
            r_carry   <= 1'b0;
            r_hinx    <= 1'b0;
            out_valid <= 1'b0;
            out_word  <= '0;
            out_flags <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                ST_IDLE: if (in_valid) begin
                    c_mode <= mode_fp;
                    c_rm   <= round_mode;
                    c_sign <= res_sign;
                    c_exp  <= res_exp;
                    c_mant <= res_mant;
                    c_ovf  <= ovf_in;
                    c_unf  <= unf_in;
                    c_inx  <= inx_in;
                end
                ST_ROUND: begin
                    r_frac  <= rnd_frac;
                    r_carry <= rnd_carry;
                    r_hinx  <= rnd_inx;
                end
                ST_PACK: begin
                    out_word  <= pk_word;
                    out_flags <= pk_flags;
                end
                ST_OUT: out_valid <= !(out_valid && out_ready);
                default: ;
            endcase
        end
    end

`ifdef FP_STICKY_FLAGS_EN
    always_ff @(posedge clk) begin
        if (rst || flag_clr)
            sticky_flags <= '0;
        else if (out_valid && out_ready)
            sticky_flags <= sticky_flags | out_flags;
    end
`endif

endmodule

// File: tb/tb_fp_result_packer.sv
// Self-checking bench for fp_result_packer: directed vector table, random model check, corner sequences.
module tb_fp_result_packer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        mode_fp = 1'b0;
    logic        round_mode = 1'b0;
    logic        res_sign = 1'b0;
    logic [7:0]  res_exp = '0;
    logic [22:0] res_mant = '0;
    logic        ovf_in = 1'b0;
    logic        unf_in = 1'b0;
    logic        inx_in = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_word;
    logic [2:0]  out_flags;
`ifdef FP_STICKY_FLAGS_EN
    logic        flag_clr = 1'b0;
    logic [2:0]  sticky_flags;
    logic [2:0]  sticky_model = '0;
`endif

    int unsigned errors = 0;
    int unsigned checks = 0;

    always #5 clk = ~clk;

    fp_result_packer dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .mode_fp    (mode_fp),
        .round_mode (round_mode),
        .res_sign   (res_sign),
        .res_exp    (res_exp),
        .res_mant   (res_mant),
        .ovf_in     (ovf_in),
        .unf_in     (unf_in),
        .inx_in     (inx_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_word   (out_word),
        .out_flags  (out_flags)
`ifdef FP_STICKY_FLAGS_EN
        ,
        .flag_clr     (flag_clr),
        .sticky_flags (sticky_flags)
`endif
    );

    typedef struct {
        logic        mode;
        logic        rm;
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] mant;
        logic        ovf;
        logic        unf;
        logic        inx;
        logic [31:0] word;
        logic [2:0]  flags;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: value-level rounding on the 13 discarded bits, then range classification.
    function automatic void ref_model(input vec_t v, output logic [31:0] w, output logic [2:0] f);
        int q, rem, h;
        bit up, hinx;
        q    = int'(v.mant) >> 13;
        rem  = int'(v.mant) & 'h1FFF;
        up   = (v.rm == 1'b0) && (rem > 'h1000 || (rem == 'h1000 && (v.inx || (q % 2 == 1))));
        hinx = (rem != 0) || v.inx;
        q    = q + int'(up);
        h    = int'(v.exp) - 127 + 15;
        if (q == 1024) begin
            q = 0;
            h = h + 1;
        end
        w = '0;
        f = '0;
        if (v.exp == 8'd255 && v.mant != 0) begin
            w = v.mode ? 32'h7FC00000 : 32'h00007E00;
        end else if (v.exp == 8'd255 || v.ovf || (!v.mode && !(v.exp == 0 || v.unf) && h >= 31)) begin
            f = 3'b101;
            w = v.mode ? (v.rm ? 32'h7F7FFFFF : 32'h7F800000) : (v.rm ? 32'h00007BFF : 32'h00007C00);
            w = w | (32'(v.sign) << (v.mode ? 31 : 15));
        end else if (v.exp == 0 || v.unf) begin
            f = {1'b0, v.inx | v.unf, v.inx};
            w = 32'(v.sign) << (v.mode ? 31 : 15);
        end else if (v.mode) begin
            f = {2'b00, v.inx};
            w = {v.sign, v.exp, v.mant};
        end else if (h <= 0) begin
            f = 3'b011;
            w = 32'(v.sign) << 15;
        end else begin
            f = {2'b00, hinx};
            w = (32'(v.sign) << 15) | (32'(h) << 10) | 32'(q);
        end
    endfunction

    task automatic drive(input vec_t v);
        mode_fp    = v.mode;
        round_mode = v.rm;
        res_sign   = v.sign;
        res_exp    = v.exp;
        res_mant   = v.mant;
        ovf_in     = v.ovf;
        unf_in     = v.unf;
        inx_in     = v.inx;
    endtask

    task automatic scramble();
        mode_fp    = 1'($urandom);
        round_mode = 1'($urandom);
        res_sign   = 1'($urandom);
        res_exp    = 8'($urandom);
        res_mant   = 23'($urandom);
        ovf_in     = 1'($urandom);
        unf_in     = 1'($urandom);
        inx_in     = 1'($urandom);
    endtask

    // Accept at edge k, expect out_valid low through k+2, high from k+3, handshake at k+4.
    task automatic run_one(input vec_t v, input string tag);
        @(negedge clk);
        check({tag, "_in_ready_idle"}, 32'(in_ready), 32'd1);
        drive(v);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        scramble();
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            check({tag, "_early_valid"}, 32'(out_valid), 32'd0);
        end
        @(posedge clk);
        #1;
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_busy"}, 32'(in_ready), 32'd0);
        check({tag, "_word"}, out_word, v.word);
        check({tag, "_flags"}, 32'(out_flags), 32'(v.flags));
        @(posedge clk);
        #1;
        check({tag, "_done_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_done_ready"}, 32'(in_ready), 32'd1);
`ifdef FP_STICKY_FLAGS_EN
        sticky_model = sticky_model | v.flags;
        check({tag, "_sticky"}, 32'(sticky_flags), 32'(sticky_model));
`endif
    endtask

    function automatic vec_t mk(input logic mode, rm, sign, input logic [7:0] e, input logic [22:0] m,
                                input logic ovf, unf, inx, input logic [31:0] w, input logic [2:0] f);
        vec_t v;
        v.mode = mode; v.rm = rm; v.sign = sign; v.exp = e; v.mant = m;
        v.ovf = ovf; v.unf = unf; v.inx = inx; v.word = w; v.flags = f;
        return v;
    endfunction

    vec_t table_v[$];
    vec_t rv;
    vec_t hv;
    logic [31:0] held_word;
    logic [2:0]  held_flags;
    logic [31:0] mw;
    logic [2:0]  mf;

    initial begin
        //             mode rm sign exp    mant       ovf unf inx  word          flags
        table_v.push_back(mk(1, 0, 0, 8'h7F, 23'h000000, 0, 0, 0, 32'h3F800000, 3'b000));
        table_v.push_back(mk(0, 0, 0, 8'h7F, 23'h400000, 0, 0, 0, 32'h00003E00, 3'b000));
        table_v.push_back(mk(0, 0, 0, 8'h7F, 23'h7FF000, 0, 0, 0, 32'h00004000, 3'b001));
        table_v.push_back(mk(0, 1, 0, 8'h7F, 23'h7FF000, 0, 0, 0, 32'h00003FFF, 3'b001));
        table_v.push_back(mk(0, 0, 0, 8'h8F, 23'h000000, 0, 0, 0, 32'h00007C00, 3'b101));
        table_v.push_back(mk(0, 1, 0, 8'h8F, 23'h000000, 0, 0, 0, 32'h00007BFF, 3'b101));
        table_v.push_back(mk(0, 0, 1, 8'h8F, 23'h000000, 0, 0, 0, 32'h0000FC00, 3'b101));
        table_v.push_back(mk(0, 0, 0, 8'h70, 23'h000000, 0, 0, 0, 32'h00000000, 3'b011));
        table_v.push_back(mk(0, 0, 0, 8'hFF, 23'h000001, 0, 0, 0, 32'h00007E00, 3'b000));
        table_v.push_back(mk(1, 0, 0, 8'hFF, 23'h000001, 0, 0, 1, 32'h7FC00000, 3'b000));
        table_v.push_back(mk(1, 1, 1, 8'hFF, 23'h000000, 0, 0, 0, 32'hFF7FFFFF, 3'b101));
        table_v.push_back(mk(1, 0, 1, 8'h10, 23'h000123, 1, 0, 0, 32'hFF800000, 3'b101));
        table_v.push_back(mk(1, 0, 1, 8'h00, 23'h000123, 0, 0, 1, 32'h80000000, 3'b011));
        table_v.push_back(mk(0, 0, 0, 8'h7F, 23'h003000, 0, 0, 0, 32'h00003C02, 3'b001));
        table_v.push_back(mk(0, 0, 0, 8'h7F, 23'h001000, 0, 0, 0, 32'h00003C00, 3'b001));
        table_v.push_back(mk(0, 0, 0, 8'h7F, 23'h001000, 0, 0, 1, 32'h00003C01, 3'b001));

        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_word", out_word, 32'd0);
        check("rst_out_flags", 32'(out_flags), 32'd0);
`ifdef FP_STICKY_FLAGS_EN
        check("rst_sticky", 32'(sticky_flags), 32'd0);
`endif
        rst = 1'b0;

        foreach (table_v[i]) run_one(table_v[i], $sformatf("vec%0d", i));

        for (int n = 0; n < 150; n++) begin
            rv.mode = 1'($urandom);
            rv.rm   = 1'($urandom);
            rv.sign = 1'($urandom);
            case ($urandom_range(0, 9))
                0:       rv.exp = 8'hFF;
                1:       rv.exp = 8'h00;
                2:       rv.exp = 8'($urandom);
                default: rv.exp = 8'($urandom_range(8'h6E, 8'h90));
            endcase
            rv.mant = ($urandom_range(0, 3) == 0) ? 23'h7FF000 | 23'($urandom_range(0, 'hFFF)) : 23'($urandom);
            if (rv.exp == 8'hFF && $urandom_range(0, 1) == 0) rv.mant = '0;
            rv.ovf = ($urandom_range(0, 15) == 0);
            rv.unf = ($urandom_range(0, 15) == 0);
            rv.inx = 1'($urandom);
            ref_model(rv, mw, mf);
            rv.word  = mw;
            rv.flags = mf;
            run_one(rv, "rand");
        end

        // Back-pressure: result held stable and input blocked while out_ready is low.
        hv = table_v[2];
        @(negedge clk);
        out_ready = 1'b0;
        drive(hv);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        held_word  = out_word;
        held_flags = out_flags;
        check("hold_word_init", held_word, hv.word);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_in_ready", 32'(in_ready), 32'd0);
            check("hold_word", out_word, held_word);
            check("hold_flags", 32'(out_flags), 32'(held_flags));
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("hold_release_valid", 32'(out_valid), 32'd0);
        check("hold_release_ready", 32'(in_ready), 32'd1);
`ifdef FP_STICKY_FLAGS_EN
        sticky_model = sticky_model | hv.flags;
        check("hold_sticky", 32'(sticky_flags), 32'(sticky_model));
`endif

        // Reset while in ROUND discards the in-flight result.
        @(negedge clk);
        drive(table_v[0]);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_ready", 32'(in_ready), 32'd1);
        check("mid_rst_word", out_word, 32'd0);
        repeat (4) begin
            @(posedge clk);
            #1;
            check("mid_rst_no_output", 32'(out_valid), 32'd0);
        end

`ifdef FP_STICKY_FLAGS_EN
        sticky_model = '0;
        check("sticky_after_rst", 32'(sticky_flags), 32'd0);
        run_one(table_v[2], "stk_a");
        run_one(table_v[7], "stk_b");
        check("sticky_accum", 32'(sticky_flags), 32'h3);
        // Clear coincident with a handshake must win over the OR.
        @(negedge clk);
        drive(table_v[4]);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        flag_clr = 1'b1;
        @(posedge clk);
        #1;
        flag_clr = 1'b0;
        sticky_model = '0;
        check("sticky_clr_priority", 32'(sticky_flags), 32'd0);
        check("sticky_clr_valid", 32'(out_valid), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
